// File: rtl/mux_select_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_arb_pkg : shared state encoding and sizing for mux_select_arbiter |
// | Revision    : 1.0                                                      |
// +----------------------------------------------------------------------+
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_e;

    localparam int unsigned c_hcnt_w = 8;

    // Select width for an N:1 mux; a 2:1 mux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_select_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_select_arbiter_if : requester-side bundle of the shared-mux arbiter|
// | Revision              : 1.0                                            |
// +----------------------------------------------------------------------+
interface mux_select_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int NREQ = 32,
    parameter int SELW = sel_width(NREQ)
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [SELW-1:0] sel;
    logic            valid;
    logic            preempt;

    modport master (output req, input grant, input sel, input valid, input preempt);
    modport slave  (input req, output grant, output sel, output valid, output preempt);
endinterface
`default_nettype wire

// File: rtl/mux_select_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick  : rotate-and-priority-encode, first set req from i_ptr upward |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int NREQ = 32,
    parameter int SELW = sel_width(NREQ)
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [SELW-1:0] i_ptr,
    output logic      [SELW-1:0] o_w,
    output logic                 o_any
);

    int              w_k;
    logic [SELW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest hit to i_ptr wins last.
    always_comb begin
        o_any = 1'b0;
        o_w   = '0;
        w_k   = 0;
        w_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end
            w_idx = SELW'(w_k);
            if (i_req[w_idx]) begin
                o_any = 1'b1;
                o_w   = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_select_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_select_arbiter : round-robin owner of a shared N:1 select mux with |
// |                      hold-limit pre-emption and a one-cycle turnaround |
// | Revision           : 1.0                                               |
// +----------------------------------------------------------------------+
module mux_select_arbiter
    import mux_arb_pkg::*;
#(
    parameter int NREQ     = 32,
    parameter int SELW     = sel_width(NREQ),
    parameter int MAX_HOLD = 16
) (
    input wire logic         clock,
    input wire logic         reset_n,
    mux_select_arbiter_if.slave bus
);

    localparam logic [c_hcnt_w-1:0] c_hold_last =
        (MAX_HOLD == 0) ? '0 : c_hcnt_w'(MAX_HOLD - 1);
    localparam logic [SELW-1:0]     c_last_idx  = SELW'(NREQ - 1);
    localparam logic [NREQ-1:0]     c_one       = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_e            state_q,   state_d;
    logic [NREQ-1:0]       grant_q,   grant_d;
    logic [SELW-1:0]       sel_q,     sel_d;
    logic                  valid_q,   valid_d;
    logic                  preempt_q, preempt_d;
    logic [SELW-1:0]       ptr_q,     ptr_d;
    logic [c_hcnt_w-1:0]   hcnt_q,    hcnt_d;

    logic [SELW-1:0]       w_idx;
    logic                  w_any;
    logic                  w_owner_req;
    logic                  w_timeout;

    rr_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_pick (
        .i_req (bus.req),
        .i_ptr (ptr_q),
        .o_w   (w_idx),
        .o_any (w_any)
    );

    assign w_owner_req = bus.req[sel_q];
    assign w_timeout   = (MAX_HOLD != 0) && (hcnt_q == c_hold_last);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (w_any) begin
                    grant_d = c_one << w_idx;
                    sel_d   = w_idx;
                    valid_d = 1'b1;
                    hcnt_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!w_owner_req || w_timeout) begin
                    // The released owner gets the lowest priority next round.
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = (sel_q == c_last_idx) ? '0 : sel_q + SELW'(1);
                    preempt_d = w_owner_req;
                    state_d   = GAP;
                end else if (hcnt_q != '1) begin
                    hcnt_d = hcnt_q + c_hcnt_w'(1);
                end
            end
            GAP: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.valid   = valid_q;
    assign bus.preempt = preempt_q;

endmodule
`default_nettype wire
